// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO.
// Optional occupancy status outputs are enabled by defining FIFO_STATUS_EN.
package sync_fifo_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int DEPTH      = 2**ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH:0]   ptr_t;
endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// FIFO_STATUS_EN adds count/almost_full/almost_empty to the bundle.
interface sync_fifo_if
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = sync_fifo_pkg::ADDR_WIDTH
);
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
`ifdef FIFO_STATUS_EN
   logic [ADDR_WIDTH:0]   count;
   logic                  almost_full;
   logic                  almost_empty;

   modport master (output wr_en, rd_en, data_in,
                   input  data_out, full, empty, count, almost_full, almost_empty);
   modport slave  (input  wr_en, rd_en, data_in,
                   output data_out, full, empty, count, almost_full, almost_empty);
`else
   modport master (output wr_en, rd_en, data_in,
                   input  data_out, full, empty);
   modport slave  (input  wr_en, rd_en, data_in,
                   output data_out, full, empty);
`endif
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one registered read port.
// Only the read register is reset; stored words survive reset untouched.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = sync_fifo_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int DEPTH_L = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH_L];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Output register holds its value unless a read is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: binary wrap-bit pointers, flags decoded from registered pointers.
// Define FIFO_STATUS_EN to expose count/almost_full/almost_empty.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = sync_fifo_pkg::ADDR_WIDTH
) (
   input  logic      clk,
   input  logic      rst_n,
   sync_fifo_if.slave bus
);
   localparam int DEPTH_L = 2**ADDR_WIDTH;
   localparam int PTR_W   = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             wr_go, rd_go;
   logic             full, empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

   // Strobes are qualified by reset too, so nothing is accepted during reset.
   assign wr_go = bus.wr_en & ~full  & rst_n;
   assign rd_go = bus.rd_en & ~empty & rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_go) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_go) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_go),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (bus.data_in),
      .re    (rd_go),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (bus.data_out)
   );

   assign bus.full  = full;
   assign bus.empty = empty;

`ifdef FIFO_STATUS_EN
   logic [PTR_W-1:0] count;

   // Modular subtraction gives occupancy 0..DEPTH thanks to the wrap bit.
   assign count            = wr_ptr - rd_ptr;
   assign bus.count        = count;
   assign bus.almost_full  = (count >= PTR_W'(DEPTH_L - 1));
   assign bus.almost_empty = (count <= PTR_W'(1));
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed + random bench for sync_fifo using a queue reference model and scoreboard.
module tb_sync_fifo;
   import sync_fifo_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_mis = 0;

   sync_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   data_t mq[$];      // reference contents of the FIFO
   data_t exp_q[$];   // scoreboard of expected read results
   data_t last_dout;
   ptr_t  saved_ptr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_empty"}, 32'(bus.empty), 32'(mq.size() == 0));
      chk({tag, "_full"},  32'(bus.full),  32'(mq.size() == DEPTH));
`ifdef FIFO_STATUS_EN
      chk({tag, "_count"}, 32'(bus.count), 32'(mq.size()));
      chk({tag, "_afull"}, 32'(bus.almost_full),  32'(mq.size() >= DEPTH - 1));
      chk({tag, "_aempty"}, 32'(bus.almost_empty), 32'(mq.size() <= 1));
`endif
   endtask

   // One clock of stimulus; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic cyc(input string tag, input logic w, input logic r, input data_t d);
      bit acc_w, acc_r;
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.data_in = d;
      acc_r = r && (mq.size() > 0);
      acc_w = w && (mq.size() < DEPTH);
      @(posedge clk); #1;
      if (acc_r) exp_q.push_back(mq.pop_front());
      if (acc_w) mq.push_back(d);
      if (acc_r) begin
         last_dout = exp_q.pop_front();
         chk({tag, "_data"}, 32'(bus.data_out), 32'(last_dout));
      end else begin
         chk({tag, "_hold"}, 32'(bus.data_out), 32'(last_dout));
      end
      chk_flags(tag);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst_n       = 1'b0;
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      bus.data_in = 8'hEE;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mq.delete();
         exp_q.delete();
         last_dout = '0;
         chk("rst_data", 32'(bus.data_out), 32'h0);
         chk_flags("rst");
         chk("rst_wr_ptr", 32'(dut.wr_ptr), 32'h0);
         chk("rst_rd_ptr", 32'(dut.rd_ptr), 32'h0);
      end
      rst_n     = 1'b1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.data_in = '0;
      last_dout   = '0;

      do_reset(2);

      // Fill, overflow attempt, then drain in order
      for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 1'b0, data_t'(i));
      chk("full_after_fill", 32'(bus.full), 32'h1);
      cyc("ovf", 1'b1, 1'b0, 8'hAA);
      for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 1'b1, '0);
      chk("empty_after_drain", 32'(bus.empty), 32'h1);
      chk("last_drained", 32'(bus.data_out), 32'h0F);

      // Underflow: data_out and read pointer must hold
      saved_ptr = dut.rd_ptr;
      for (int i = 0; i < 3; i++) cyc("udf", 1'b0, 1'b1, '0);
      chk("udf_rd_ptr", 32'(dut.rd_ptr), 32'(saved_ptr));

      // Simultaneous push/pop at steady occupancy
      for (int i = 0; i < 5; i++) cyc("load5", 1'b1, 1'b0, data_t'(8'h20 + i));
      for (int i = 0; i < 10; i++) cyc("simul", 1'b1, 1'b1, data_t'(8'h30 + i));
      while (mq.size() > 0) cyc("drain2", 1'b0, 1'b1, '0);

      // Empty with both strobes: write only, no bypass
      cyc("empty_both", 1'b1, 1'b1, 8'h55);
      chk("empty_both_notempty", 32'(bus.empty), 32'h0);
      cyc("read55", 1'b0, 1'b1, '0);
      chk("read55_val", 32'(bus.data_out), 32'h55);

      // Full with both strobes: read only, write dropped
      for (int i = 0; i < DEPTH; i++) cyc("fill2", 1'b1, 1'b0, data_t'(8'h60 + i));
      cyc("full_both", 1'b1, 1'b1, 8'h77);
      chk("full_both_notfull", 32'(bus.full), 32'h0);
      chk("full_both_data", 32'(bus.data_out), 32'h60);
      while (mq.size() > 0) cyc("drain3", 1'b0, 1'b1, '0);

      // Random traffic across pointer wrap
      for (int i = 0; i < 40; i++)
         cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             data_t'($urandom_range(0, 255)));

      // Settle on 7 stored words, then reset mid-operation
      for (int i = 0; i < 40 && mq.size() != 7; i++) begin
         if (mq.size() < 7) cyc("to7", 1'b1, 1'b0, data_t'(8'hC0 + i));
         else               cyc("to7", 1'b0, 1'b1, '0);
      end
      chk("seven_stored", 32'(mq.size()), 32'd7);
      do_reset(1);
      cyc("post_rst_udf", 1'b0, 1'b1, '0);
      cyc("post_rst_wr", 1'b1, 1'b0, 8'h99);
      cyc("post_rst_rd", 1'b0, 1'b1, '0);
      chk("post_rst_val", 32'(bus.data_out), 32'h99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
